// File: rtl/sweep_stimulus_driver.sv
// Sweeps every 4-valued input vector (2-bit digits 0/1/X/Z) through a downstream
// comparator one at a time and tallies fails, first failing vector and timeouts.
module sweep_stimulus_driver #(
    parameter int NDIGITS = 8,
    parameter int CNTW    = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 vec_valid,
    input  logic                 vec_ready,
    output logic [2*NDIGITS-1:0] vec_code,
    input  logic                 resp_valid,
    input  logic                 resp_ok,
    output logic                 busy,
    output logic                 done,
    output logic [CNTW-1:0]      fail_count,
    output logic                 first_fail_valid,
    output logic [2*NDIGITS-1:0] first_fail_code,
    output logic                 timeout_seen,
    output logic                 stray_resp
);

    localparam int VW = 2 * NDIGITS;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] timer;

    logic start_ok;
    logic issue_fire;
    logic wait_resp;
    logic wait_to;
    logic complete;
    logic fail_now;
    logic last_vec;

    // Handshake: a vector transfers on a cycle where vec_valid && vec_ready; vec_code
    // stays stable while vec_valid is high and not yet accepted. A response is only
    // accepted in WAIT, so at most one vector is ever outstanding.
    assign vec_valid = (state == ISSUE);
    assign busy      = (state == ISSUE) || (state == WAIT);
    assign done      = (state == DONE);

    assign start_ok   = start && ((state == IDLE) || (state == DONE));
    assign issue_fire = (state == ISSUE) && vec_ready;
    assign wait_resp  = (state == WAIT) && resp_valid;
    assign wait_to    = (state == WAIT) && !resp_valid && (timer == TMAX);
    assign complete   = wait_resp || wait_to;
    assign fail_now   = wait_to || (wait_resp && !resp_ok);
    assign last_vec   = &vec_code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = ISSUE;
            ISSUE:   if (issue_fire) state_nxt = WAIT;
            WAIT:    if (complete) state_nxt = last_vec ? DONE : ISSUE;
            DONE:    if (start_ok) state_nxt = ISSUE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_code         <= '0;
            timer            <= '0;
            fail_count       <= '0;
            first_fail_valid <= 1'b0;
            first_fail_code  <= '0;
            timeout_seen     <= 1'b0;
            stray_resp       <= 1'b0;
        end else if (start_ok) begin
            vec_code         <= '0;
            timer            <= '0;
            fail_count       <= '0;
            first_fail_valid <= 1'b0;
            first_fail_code  <= '0;
            timeout_seen     <= 1'b0;
            stray_resp       <= 1'b0;
        end else begin
            // Includes a response landing in the same cycle as the ISSUE handshake.
            if (resp_valid && (state != WAIT)) begin
                stray_resp <= 1'b1;
            end

            if (issue_fire) begin
                timer <= '0;
            end else if ((state == WAIT) && !complete) begin
                timer <= timer + 1'b1;
            end

            if (complete) begin
                if (fail_now) begin
                    if (fail_count != {CNTW{1'b1}}) begin
                        fail_count <= fail_count + 1'b1;
                    end
                    if (!first_fail_valid) begin
                        first_fail_valid <= 1'b1;
                        first_fail_code  <= vec_code;
                    end
                end
                if (wait_to) begin
                    timeout_seen <= 1'b1;
                end
                if (!last_vec) begin
                    vec_code <= vec_code + VW'(1);
                end
            end
        end
    end

endmodule
